keycode_repeat_mapper: RTL and testbench

- Parametrised successor to the single-keycode mapper.
- Scans NUM_KEYS keycode slots from the USB HID report and selects one active key.
- Decodes the active key to cursor/edit action codes, emitted as one-cycle event pulses.
- Generates a press event, then typematic auto-repeat events with configurable delay and period; sits between the USB keycode registers and the tracker cursor/edit logic.

---
 rtl/keycode_repeat_mapper.sv | 138 +++++++++++++
 tb/tb_keycode_repeat_mapper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keycode_repeat_mapper.sv
// Keycode repeat mapper.
// Scans NUM_KEYS HID keycode slots and picks the lowest-index recognised key.
// The key is decoded to cursor/edit action codes, which are emitted as
// one-cycle event pulses.
// A press event is followed by typematic auto-repeat events.
module keycode_repeat_mapper #(
  parameter int NUM_KEYS      = 2,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [8*NUM_KEYS-1:0]   keycodes,
  output logic [2:0]              user_cursor,
  output logic [1:0]              user_edit,
  output logic                    event_valid
);

  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [7:0]    KEY_NONE    = 8'h00;
  localparam logic [7:0]    KEY_DELETE  = 8'h13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Map a HID keycode to {cursor[2:0], edit[1:0]}; all-zero means unrecognised.
  function automatic logic [4:0] decode_key(input logic [7:0] code);
    logic [4:0] act;
    case (code)
      8'h1A:   act = {3'b011, 2'b00};  // up
      8'h04:   act = {3'b001, 2'b00};  // left
      8'h16:   act = {3'b100, 2'b00};  // down
      8'h07:   act = {3'b010, 2'b00};  // right
      8'h0C:   act = {3'b000, 2'b01};  // increment
      8'h0E:   act = {3'b000, 2'b10};  // decrement
      8'h13:   act = {3'b000, 2'b11};  // delete
      default: act = 5'b00000;
    endcase
    return act;
  endfunction

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [7:0]      latched_r;
  logic [7:0]      active_key_s;
  logic [4:0]      active_dec_s;
  logic            repeat_ok_s;
  logic [CW-1:0]   term_s;

  // Select the lowest-index slot holding a recognised keycode.
  always_comb begin
    active_key_s = KEY_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (decode_key(keycodes[8*i +: 8]) != 5'b00000) begin
        active_key_s = keycodes[8*i +: 8];
      end else begin
        active_key_s = active_key_s;
      end
    end
  end

  // Decode the active key and derive the repeat qualifiers for this state.
  always_comb begin
    active_dec_s = decode_key(active_key_s);
    repeat_ok_s  = (REPEAT_EN != 0) && (active_key_s != KEY_DELETE);
    if (state_r == REPEAT) begin
      term_s = PERIOD_LAST;
    end else begin
      term_s = DELAY_LAST;
    end
  end

  // Press/repeat FSM with registered event outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      count_r     <= '0;
      latched_r   <= KEY_NONE;
      user_cursor <= 3'b000;
      user_edit   <= 2'b00;
      event_valid <= 1'b0;
    end else begin
      user_cursor <= 3'b000;
      user_edit   <= 2'b00;
      event_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (active_key_s != KEY_NONE) begin
            {user_cursor, user_edit} <= active_dec_s;
            event_valid <= 1'b1;
            latched_r   <= active_key_s;
            count_r     <= '0;
            state_r     <= DELAY;
          end else begin
            state_r     <= IDLE;
          end
        end
        DELAY, REPEAT: begin
          if (active_key_s == KEY_NONE) begin
            latched_r <= KEY_NONE;
            count_r   <= '0;
            state_r   <= IDLE;
          end else if (active_key_s != latched_r) begin
            // A different key (even with no gap cycle) is a fresh press.
            {user_cursor, user_edit} <= active_dec_s;
            event_valid <= 1'b1;
            latched_r   <= active_key_s;
            count_r     <= '0;
            state_r     <= DELAY;
          end else if (!repeat_ok_s) begin
            // Delete, or repeat disabled: sit here with the counter frozen.
            count_r <= count_r;
          end else if (count_r == term_s) begin
            {user_cursor, user_edit} <= active_dec_s;
            event_valid <= 1'b1;
            count_r     <= '0;
            state_r     <= REPEAT;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          count_r   <= '0;
          latched_r <= KEY_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_repeat_mapper.sv
// Bench for keycode_repeat_mapper: a directed vector table, a few hand-written
// sequences, and random stimulus against a reference model that reasons in
// terms of "cycles since the last press event".
module tb_keycode_repeat_mapper;

  localparam int NK = 2;
  localparam int D  = 4;
  localparam int P  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic [2:0]  cur_a, cur_b;
  logic [1:0]  ed_a, ed_b;
  logic        ev_a, ev_b;

  always #5 clk = ~clk;

  keycode_repeat_mapper #(.NUM_KEYS(NK), .REPEAT_EN(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut_a (
    .clk(clk), .Reset(rst), .keycodes(keys),
    .user_cursor(cur_a), .user_edit(ed_a), .event_valid(ev_a));

  keycode_repeat_mapper #(.NUM_KEYS(NK), .REPEAT_EN(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut_b (
    .clk(clk), .Reset(rst), .keycodes(keys),
    .user_cursor(cur_b), .user_edit(ed_b), .event_valid(ev_b));

  int total = 0;
  int bad   = 0;

  // Reference model state, per instance (0: repeat on, 1: repeat off).
  logic [7:0] m_held [2];
  int         m_age  [2];
  logic [5:0] m_exp  [2];
  int         ev_cnt_a, ev_cnt_b;

  typedef struct {
    logic        r;
    logic [15:0] k;
    logic [5:0]  exp;   // {valid, cursor, edit}
  } vec_t;
  vec_t tbl[$];

  function automatic logic [4:0] dec(input logic [7:0] k);
    case (k)
      8'h1A: return 5'b011_00;
      8'h04: return 5'b001_00;
      8'h16: return 5'b100_00;
      8'h07: return 5'b010_00;
      8'h0C: return 5'b000_01;
      8'h0E: return 5'b000_10;
      8'h13: return 5'b000_11;
      default: return 5'b000_00;
    endcase
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] kc);
    for (int i = 0; i < NK; i++) begin
      if (dec(kc[8*i +: 8]) != 5'd0) return kc[8*i +: 8];
    end
    return 8'h00;
  endfunction

  task automatic model_edge(input int u, input bit ren);
    logic [7:0] a;
    a = pick(keys);
    m_exp[u] = 6'd0;
    if (rst) begin
      m_held[u] = 8'h00;
      m_age[u]  = 0;
    end else if (a == 8'h00) begin
      m_held[u] = 8'h00;
      m_age[u]  = 0;
    end else if (a != m_held[u]) begin
      m_held[u] = a;
      m_age[u]  = 0;
      m_exp[u]  = {1'b1, dec(a)};
    end else begin
      m_age[u] = m_age[u] + 1;
      if (ren && a != 8'h13 &&
          (m_age[u] == D || (m_age[u] > D && ((m_age[u] - D) % P) == 0)))
        m_exp[u] = {1'b1, dec(a)};
    end
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] k);
    rst  = r;
    keys = k;
    @(posedge clk);
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
    #1;
    ev_cnt_a += int'(ev_a);
    ev_cnt_b += int'(ev_b);
    check("model_a", {ev_a, cur_a, ed_a}, m_exp[0]);
    check("model_b", {ev_b, cur_b, ed_b}, m_exp[1]);
  endtask

  task automatic add(input logic r, input logic [15:0] k, input logic [5:0] exp);
    vec_t v;
    v.r = r; v.k = k; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] pool [10];
    logic [7:0] k0, k1;
    logic       r;
    int         len;
    pool = '{8'h00, 8'h04, 8'h07, 8'h0C, 8'h0E, 8'h13, 8'h16, 8'h1A, 8'h05, 8'hFF};
    m_held = '{8'h00, 8'h00};
    m_age  = '{0, 0};
    ev_cnt_a = 0;
    ev_cnt_b = 0;
    rst  = 1'b1;
    keys = 16'h0000;

    // Reset state.
    add(1'b1, 16'h001A, 6'd0);
    add(1'b1, 16'h0000, 6'd0);
    // Hold W: events at ages 0,4,6,8,10.
    for (int i = 0; i < 12; i++)
      add(1'b0, 16'h001A, (i == 0 || i == 4 || i == 6 || i == 8 || i == 10) ? 6'b1_011_00 : 6'd0);
    add(1'b0, 16'h0000, 6'd0);
    // Unrecognised slot0 skipped, then slot0 becomes left: immediate press.
    add(1'b0, 16'h0C05, 6'b1_000_01);
    add(1'b0, 16'h0C04, 6'b1_001_00);
    add(1'b0, 16'h0C04, 6'd0);
    add(1'b0, 16'h0C04, 6'd0);
    add(1'b0, 16'h0C04, 6'd0);
    add(1'b0, 16'h0C04, 6'b1_001_00);
    // Same code moving slots is not a change.
    add(1'b0, 16'h0000, 6'd0);
    add(1'b0, 16'h001A, 6'b1_011_00);
    add(1'b0, 16'h1A00, 6'd0);
    add(1'b0, 16'h1A00, 6'd0);
    // A released and B present same cycle: press for B.
    add(1'b0, 16'h0016, 6'b1_100_00);
    // D held then released at E3, re-press.
    add(1'b0, 16'h0000, 6'd0);
    add(1'b0, 16'h0007, 6'b1_010_00);
    add(1'b0, 16'h0007, 6'd0);
    add(1'b0, 16'h0007, 6'd0);
    add(1'b0, 16'h0000, 6'd0);
    add(1'b0, 16'h0000, 6'd0);
    add(1'b0, 16'h0007, 6'b1_010_00);
    add(1'b0, 16'h0000, 6'd0);
    // W for 5 cycles, reset 2 cycles with W held, then press again.
    for (int i = 0; i < 5; i++)
      add(1'b0, 16'h001A, (i == 0 || i == 4) ? 6'b1_011_00 : 6'd0);
    add(1'b1, 16'h001A, 6'd0);
    add(1'b1, 16'h001A, 6'd0);
    add(1'b0, 16'h001A, 6'b1_011_00);
    add(1'b0, 16'h0000, 6'd0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].k);
      check($sformatf("tbl[%0d]", i), {ev_a, cur_a, ed_a}, tbl[i].exp);
    end

    // Delete held 20 cycles: exactly one event, edit=11.
    ev_cnt_a = 0;
    step(1'b0, 16'h0013);
    check("del_press", {ev_a, cur_a, ed_a}, 6'b1_000_11);
    for (int i = 0; i < 19; i++) step(1'b0, 16'h0013);
    total++;
    if (ev_cnt_a != 1) begin
      bad++;
      $display("FAIL del_count got=%0d want=1", ev_cnt_a);
    end
    step(1'b0, 16'h0000);

    // Repeat disabled: K held 20 cycles gives a single decrement event.
    ev_cnt_b = 0;
    step(1'b0, 16'h000E);
    check("norep_press", {ev_b, cur_b, ed_b}, 6'b1_000_10);
    for (int i = 0; i < 19; i++) step(1'b0, 16'h000E);
    total++;
    if (ev_cnt_b != 1) begin
      bad++;
      $display("FAIL norep_count got=%0d want=1", ev_cnt_b);
    end
    step(1'b0, 16'h0000);

    // Random stimulus against the model.
    for (int n = 0; n < 150; n++) begin
      k0  = pool[$urandom_range(0, 9)];
      k1  = pool[$urandom_range(0, 9)];
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        r = ($urandom_range(0, 59) == 0);
        step(r, {k1, k0});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
